uart_rx: RTL and testbench

Serial receive front end of the UART: oversamples the asynchronous RX line, deframes start / 8 data / parity / stop, and presents the recovered byte with parity and framing status. It sits between the pin and the byte consumer. It feeds the received word into a `parity_checker` instance and compares that result against the received parity bit. Line format is fixed 8-O-1: LSB first, odd parity. The transmitted parity bit is 1 when the data contains an even number of ones.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 31 +++
 rtl/parity_checker.sv | 13 +
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and the fixed 8-O-1 frame format.
// Imported by uart_rx now and by uart_tx later.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_WORD_SIZE    = 8;
  localparam bit PARITY_ODD        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bundle between the UART receiver and its consumer.
// The receiver drives it through master, the consumer reads through slave.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = UART_WORD_SIZE
);

  logic [WORD_SIZE-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input parity_err,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/parity_checker.sv
// Computes the parity bit a transmitter would send for a data word.
// Odd convention: the bit makes the total count of ones odd.
module parity_checker #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             par_o
);

  assign par_o = ODD ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_rx.sv
// UART 8-O-1 receiver: synchronizes RX, deframes by mid-bit sampling,
// and reports each word with its parity and framing status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int WORD_SIZE    = UART_WORD_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST    = IW'(WORD_SIZE - 1);

  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic rx_meta_q, rx_s;
  logic [WORD_SIZE-1:0] sh_q;
  logic par_q;
  logic [WORD_SIZE-1:0] data_q;
  logic valid_q, perr_q, ferr_q;

  logic tick_half, tick_full;
  logic smp_data, smp_par, smp_stop;
  logic exp_par;

  // Two-flop synchronizer; idles high so reset never fakes a start bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick_half) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick_full) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick_full) state_d = STOP;
      end
      STOP: begin
        if (tick_full) state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_comb begin
    smp_data = 1'b0;
    smp_par  = 1'b0;
    smp_stop = 1'b0;
    o_busy   = 1'b1;
    unique case (1'b1)
      state_q == IDLE:   o_busy   = 1'b0;
      state_q == DATA:   smp_data = tick_full;
      state_q == PARITY: smp_par  = tick_full;
      state_q == STOP:   smp_stop = tick_full;
      default: ;
    endcase
  end

  parity_checker #(
    .WIDTH(WORD_SIZE),
    .ODD  (PARITY_ODD)
  ) u_par (
    .data_i(sh_q),
    .par_o (exp_par)
  );

  // Word and status are delivered even on error, never sticky
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= smp_stop;
      if (smp_data) sh_q <= {rx_s, sh_q[WORD_SIZE-1:1]};
      if (smp_par) par_q <= rx_s;
      if (smp_stop) begin
        data_q <= sh_q;
        perr_q <= par_q != exp_par;
        ferr_q <= !rx_s;
      end
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Frames are driven as 11 bit-slots; timings are checked in cycles.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   cyc = 0;

  uart_rx_if #(.WORD_SIZE(8)) rif ();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .WORD_SIZE   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (rif.data),
    .o_valid     (rif.valid),
    .o_parity_err(rif.parity_err),
    .o_frame_err (rif.frame_err),
    .o_busy      (rif.busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  int vcnt  = 0;
  int vcyc  = -1;
  int vprev = -1;
  int rise  = -1;
  int fall  = -1;
  logic [7:0] vdata = '0;
  logic vperr = 1'b0;
  logic vferr = 1'b0;
  logic busy_p = 1'b0;

  always @(negedge clk) begin
    if (rif.valid === 1'b1) begin
      vcnt++;
      vprev = vcyc;
      vcyc  = cyc;
      vdata = rif.data;
      vperr = rif.parity_err;
      vferr = rif.frame_err;
    end
    if (rif.busy === 1'b1 && !busy_p) rise = cyc;
    if (rif.busy === 1'b0 && busy_p) fall = cyc;
    busy_p = (rif.busy === 1'b1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts on the current cycle; returns 176 cycles later
  task automatic send(input logic [7:0] d,
                      input logic p,
                      input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      idle(CPB);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int n;
    idle(3);
    check("rst_valid", 32'(rif.valid), 32'd0);
    check("rst_data", 32'(rif.data), 32'h00);
    check("rst_busy", 32'(rif.busy), 32'd0);
    check("rst_perr", 32'(rif.parity_err), 32'd0);
    check("rst_ferr", 32'(rif.frame_err), 32'd0);
    rst = 1'b0;
    idle(4);

    d = cyc;
    send(8'hA5, 1'b1, 1'b1);
    idle(5);
    check("a5_cnt", 32'(vcnt), 32'd1);
    check("a5_vcyc", 32'(vcyc), 32'(d + 171));
    check("a5_data", 32'(vdata), 32'hA5);
    check("a5_perr", 32'(vperr), 32'd0);
    check("a5_ferr", 32'(vferr), 32'd0);
    check("a5_rise", 32'(rise), 32'(d + 3));
    check("a5_fall", 32'(fall), 32'(d + 171));

    send(8'h01, 1'b1, 1'b1);
    idle(5);
    check("p01_data", 32'(vdata), 32'h01);
    check("p01_perr", 32'(vperr), 32'd1);
    check("p01_ferr", 32'(vferr), 32'd0);

    n = vcnt;
    d = cyc;
    send(8'h3C, 1'b1, 1'b0);
    idle(49);
    check("brk_busy", 32'(rif.busy), 32'd1);
    idle(1);
    rx = 1'b1;
    idle(40);
    check("brk_cnt", 32'(vcnt), 32'(n + 1));
    check("brk_vcyc", 32'(vcyc), 32'(d + 171));
    check("brk_data", 32'(vdata), 32'h3C);
    check("brk_perr", 32'(vperr), 32'd0);
    check("brk_ferr", 32'(vferr), 32'd1);
    check("brk_fall", 32'(fall), 32'(d + 229));

    n = vcnt;
    d = cyc;
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(40);
    check("gl_cnt", 32'(vcnt), 32'(n));
    check("gl_rise", 32'(rise), 32'(d + 3));
    check("gl_fall", 32'(fall), 32'(d + 11));

    n = vcnt;
    d = cyc;
    send(8'h55, 1'b1, 1'b1);
    check("b2b_d0", 32'(vdata), 32'h55);
    send(8'hFF, 1'b1, 1'b1);
    idle(5);
    check("b2b_cnt", 32'(vcnt), 32'(n + 2));
    check("b2b_gap", 32'(vcyc - vprev), 32'd176);
    check("b2b_vcyc", 32'(vcyc), 32'(d + 347));
    check("b2b_data", 32'(vdata), 32'hFF);
    check("b2b_perr", 32'(vperr), 32'd0);
    check("b2b_ferr", 32'(vferr), 32'd0);

    n = vcnt;
    fork
      send(8'hF3, 1'b1, 1'b1);
      begin
        idle(88);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mr_data", 32'(rif.data), 32'h00);
        check("mr_valid", 32'(rif.valid), 32'd0);
        check("mr_busy", 32'(rif.busy), 32'd0);
        check("mr_perr", 32'(rif.parity_err), 32'd0);
        check("mr_ferr", 32'(rif.frame_err), 32'd0);
      end
    join
    idle(20);
    check("mr_cnt", 32'(vcnt), 32'(n));
    send(8'h7E, 1'b1, 1'b1);
    idle(5);
    check("mr_cnt2", 32'(vcnt), 32'(n + 1));
    check("mr_7e", 32'(vdata), 32'h7E);
    check("mr_7e_perr", 32'(vperr), 32'd0);
    check("mr_7e_ferr", 32'(vferr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
